// File: rtl/tmds_multi_channel_receiver_if.sv
// Signal bundle for the TMDS receive front end: serial lanes in, decoded words out.
// word_valid is a one-cycle strobe with no ready; data_out/ctrl_out/de are stable from that strobe until the next.
interface tmds_multi_channel_receiver_if #(
  parameter int NUM_CHANNELS = 3
);
  logic                      enable;
  logic [NUM_CHANNELS-1:0]   serial_in;
  logic [8*NUM_CHANNELS-1:0] data_out;
  logic [2*NUM_CHANNELS-1:0] ctrl_out;
  logic                      de;
  logic                      word_valid;
  logic                      locked;

  modport master (
    output enable, serial_in,
    input  data_out, ctrl_out, de, word_valid, locked
  );

  modport slave (
    input  enable, serial_in,
    output data_out, ctrl_out, de, word_valid, locked
  );
endinterface

// File: rtl/tmds_multi_channel_receiver.sv
// Multi-lane TMDS receiver: per-lane deserialiser, lane-0 token word alignment with
// lock/loss tracking, and registered per-lane 8b/10b TMDS decode.
module tmds_multi_channel_receiver #(
  parameter int NUM_CHANNELS = 3,
  parameter int LOCK_TOKENS  = 4,
  parameter int MAX_DATA_RUN = 2048
) (
  input  logic                         clk,
  input  logic                         rst,
  tmds_multi_channel_receiver_if.slave bus,
  output logic [1:0]                   fsm_state
);
  localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 2);
  localparam logic [TOK_W-1:0] TOK_LOCK  = TOK_W'(LOCK_TOKENS);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [9:0]       sr      [NUM_CHANNELS];
  logic [9:0]       sr_next [NUM_CHANNELS];
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [TOK_W-1:0] tok_cnt, tok_cnt_next, tok_inc;
  logic [RUN_W-1:0] run_cnt, run_cnt_next, run_inc;
  logic             pending, pending_next;
  logic             boundary;
  logic             lane0_token;

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [1:0] token_code(input logic [9:0] w);
    case (w)
      10'h0AB: return 2'b01;
      10'h154: return 2'b10;
      10'h2AB: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Undo the optional inversion, then the XOR/XNOR transition chain selected by q[8].
  function automatic logic [7:0] decode_word(input logic [9:0] w);
    logic [8:0] q;
    logic [7:0] d;
    q    = w[9] ? {w[8], ~w[7:0]} : w[8:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  always_comb begin
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      sr_next[n] = {bus.serial_in[n], sr[n][9:1]};
    end
  end

  assign boundary    = (bit_cnt == 4'd9);
  assign lane0_token = is_token(sr_next[0]);
  assign tok_inc     = tok_cnt + TOK_W'(1);
  assign run_inc     = run_cnt + RUN_W'(1);
  assign fsm_state   = state;

  always_comb begin
    state_next   = state;
    bit_cnt_next = boundary ? 4'd0 : bit_cnt + 4'd1;
    tok_cnt_next = tok_cnt;
    run_cnt_next = run_cnt;
    pending_next = 1'b0;
    unique case (state)
      HUNT: begin
        // A token can complete on any bit; realign the word counter to it.
        if (lane0_token) begin
          bit_cnt_next = 4'd0;
          tok_cnt_next = TOK_W'(1);
          run_cnt_next = '0;
          state_next   = (LOCK_TOKENS == 1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (lane0_token) begin
            tok_cnt_next = tok_inc;
            if (tok_inc == TOK_LOCK) begin
              state_next   = LOCKED;
              run_cnt_next = '0;
            end
          end else begin
            tok_cnt_next = '0;
            state_next   = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          run_cnt_next = lane0_token ? '0 : run_inc;
          if (!lane0_token && (run_inc == RUN_LIMIT)) begin
            state_next   = HUNT;
            tok_cnt_next = '0;
          end else begin
            pending_next = 1'b1;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      bit_cnt <= '0;
      tok_cnt <= '0;
      run_cnt <= '0;
      pending <= 1'b0;
      for (int n = 0; n < NUM_CHANNELS; n++) sr[n] <= '0;
    end else if (bus.enable) begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      tok_cnt <= tok_cnt_next;
      run_cnt <= run_cnt_next;
      pending <= pending_next;
      for (int n = 0; n < NUM_CHANNELS; n++) sr[n] <= sr_next[n];
    end
  end

  // Decode one edge after the boundary; sr still holds the completed word then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out   <= '0;
      bus.ctrl_out   <= '0;
      bus.de         <= 1'b0;
      bus.word_valid <= 1'b0;
      bus.locked     <= 1'b0;
    end else begin
      bus.locked     <= (state == LOCKED);
      bus.word_valid <= 1'b0;
      if (bus.enable && pending) begin
        bus.word_valid <= 1'b1;
        bus.de         <= !is_token(sr[0]);
        for (int n = 0; n < NUM_CHANNELS; n++) begin
          if (is_token(sr[n])) begin
            bus.data_out[8*n +: 8] <= 8'h00;
            bus.ctrl_out[2*n +: 2] <= token_code(sr[n]);
          end else begin
            bus.data_out[8*n +: 8] <= decode_word(sr[n]);
          end
        end
      end
    end
  end
endmodule
